hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port `clk` (in, 1): rising-edge clock for all state.
REQ-003 SHALL have port `rst` (in, 1): asynchronous active-high reset.
REQ-004 SHALL have port `valid_id` (in, 1): IF/ID register holds a real instruction.
REQ-005 SHALL have ports `rs1_id`, `rs2_id` (in, 5 each): source registers of the ID-stage instruction.
REQ-006 SHALL have ports `use_rs1_id`, `use_rs2_id` (in, 1 each): the ID instruction reads rs1 / rs2.
REQ-007 SHALL have port `rd_id` (in, 5): destination register of the ID instruction.
REQ-008 SHALL have ports `reg_write_id`, `mem_read_id` (in, 1 each): control bits of the ID instruction.
REQ-009 SHALL have port `branch_taken_ex` (in, 1): the branch in EX resolved taken (zero & branch).
REQ-010 SHALL have ports `stall_if`, `stall_id` (out, 1 each): hold the PC and hold IF/ID.
REQ-011 SHALL have ports `flush_id`, `flush_ex` (out, 1 each): clear IF/ID, and insert a bubble into ID/EX.
REQ-012 SHALL have ports `fwd_a`, `fwd_b` (out, 2 each): ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
REQ-013 SHALL have ports `stall_count`, `flush_count` (out, 16 each): saturating event counters.
REQ-014 SHALL have port `state` (out, 2): FSM state (00 RUN, 01 BR_FLUSH).

Function
REQ-015 SHALL keep an internal shadow of the pipeline:
- EX slot: valid, rs1, rs2, rd, we, mr.
- MEM slot: valid, rd, we.
- WB slot: valid, rd, we.
REQ-016 SHALL, on each clk edge:
- WB <= MEM;
- MEM <= EX;
- EX <= ID fields with valid = valid_id, or a bubble (valid = 0, we = 0, mr = 0) when flush_ex = 1.
REQ-017 SHALL detect load-use hazard LU when all of the following hold:
- EX.valid & EX.mr & EX.we & EX.rd != 0 & valid_id;
- (use_rs1_id & rs1_id == EX.rd) | (use_rs2_id & rs2_id == EX.rd).
REQ-018 SHALL, in RUN with branch_taken_ex = 0 and LU = 1, drive stall_if = stall_id = flush_ex = 1 and flush_id = 0 in the same cycle (combinational), giving exactly a 1-cycle stall per hazard.
REQ-019 SHALL, in RUN with branch_taken_ex = 1:
- drive flush_id = flush_ex = 1 and stall_if = stall_id = 0, whatever LU is (branch has priority);
- go to BR_FLUSH on the next edge.
REQ-020 SHALL, in BR_FLUSH:
- drive flush_id = 1 and flush_ex = 1 (covers the one-cycle instruction-fetch latency after redirect);
- drive stall outputs 0 and ignore LU and branch_taken_ex;
- return to RUN on the next edge.
REQ-021 SHALL make the total taken-branch penalty exactly 2 cycles.
REQ-022 SHALL compute fwd_a combinationally from the EX slot, with priority:
- 10 if MEM.valid & MEM.we & MEM.rd != 0 & MEM.rd == EX.rs1;
- else 01 if WB.valid & WB.we & WB.rd != 0 & WB.rd == EX.rs1;
- else 00.
REQ-023 SHALL compute fwd_b identically using EX.rs2.
REQ-024 SHALL drive fwd_a = fwd_b = 00 when EX.valid = 0.
REQ-025 SHALL never forward or stall on register x0.
REQ-026 SHALL increment stall_count on every edge where stall_if = 1, and saturate at 16'hFFFF.
REQ-027 SHALL increment flush_count on every edge where flush_id = 1, and saturate at 16'hFFFF.
REQ-028 SHALL treat flush_ex as the EX-slot bubble source for REQ-016 in both LU and flush cases.

Reset
REQ-029 SHALL, while rst = 1, asynchronously clear:
- all slot valid/we/mr bits;
- state = RUN;
- both counters = 0.
REQ-030 SHALL hold all outputs at 0 during reset: stall_*, flush_*, fwd_* = 00, state = 00.
REQ-031 SHALL, when rst is asserted in BR_FLUSH or during a stall, abandon that operation with no residual flush or stall after rst deasserts.
REQ-032 SHALL, after rst deasserts, issue no forwarding until real instructions have propagated, because all slots are empty.

Verification
REQ-033 SHALL pass: ld x5 (rd = 5, we = 1, mr = 1) in EX, ID add reads rs1 = 5 -> one cycle of stall_if = stall_id = flush_ex = 1; next cycle no stall; fwd_a = 01 when add reaches EX; stall_count = 1.
REQ-034 SHALL pass: add x3 followed by sub reading rs2 = 3 -> fwd_b = 10 with no stall; with one NOP between them -> fwd_b = 01.
REQ-035 SHALL pass: branch_taken_ex = 1 for one cycle with LU also true -> flush_id = flush_ex = 1 for 2 consecutive cycles, stall_if = 0, state 00 -> 01 -> 00, flush_count = 2.
REQ-036 SHALL pass: rd = 0 with we = 1 and rs1 = 0 in the following instruction, including the load case -> fwd_a = 00 and no stall.
REQ-037 SHALL pass: rst asserted mid-BR_FLUSH -> immediate state = 00, counters = 0, flush_id = 0; after release, one clean instruction produces no forwarding.
REQ-038 SHALL pass: force 70000 back-to-back load-use hazards -> stall_count saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, taken-branch flush, operand forwarding
// Keeps a shadow of the EX/MEM/WB slots to drive stall, flush and forwarding controls.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_id,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        use_rs1_id,
    input  logic        use_rs2_id,
    input  logic [4:0]  rd_id,
    input  logic        reg_write_id,
    input  logic        mem_read_id,
    input  logic        branch_taken_ex,
    output logic        stall_if,
    output logic        stall_id,
    output logic        flush_id,
    output logic        flush_ex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_BR_FLUSH = 2'b01
    } state_e;

    state_e      state_q, state_d;
    logic        ex_valid_q, ex_we_q, ex_mr_q;
    logic [4:0]  ex_rs1_q, ex_rs2_q, ex_rd_q;
    logic        mem_valid_q, mem_we_q;
    logic [4:0]  mem_rd_q;
    logic        wb_valid_q, wb_we_q;
    logic [4:0]  wb_rd_q;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic load_use;
    logic stall_d, flush_id_d, flush_ex_d;

    assign load_use = ex_valid_q && ex_mr_q && ex_we_q && (ex_rd_q != 5'd0) && valid_id &&
                      ((use_rs1_id && (rs1_id == ex_rd_q)) || (use_rs2_id && (rs2_id == ex_rd_q)));

    // Branch redirect outranks load-use; BR_FLUSH squashes the wrong-path fetch after redirect.
    always_comb begin
        stall_d    = 1'b0;
        flush_id_d = 1'b0;
        flush_ex_d = 1'b0;
        state_d    = state_q;
        if (state_q == ST_BR_FLUSH) begin
            flush_id_d = 1'b1;
            flush_ex_d = 1'b1;
            state_d    = ST_RUN;
        end else if (branch_taken_ex) begin
            flush_id_d = 1'b1;
            flush_ex_d = 1'b1;
            state_d    = ST_BR_FLUSH;
        end else if (load_use) begin
            stall_d    = 1'b1;
            flush_ex_d = 1'b1;
        end
    end

    assign stall_if    = stall_d && !rst;
    assign stall_id    = stall_d && !rst;
    assign flush_id    = flush_id_d && !rst;
    assign flush_ex    = flush_ex_d && !rst;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
    assign state       = state_q;

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (ex_valid_q) begin
            if (mem_valid_q && mem_we_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs1_q))
                fwd_a = 2'b10;
            else if (wb_valid_q && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs1_q))
                fwd_a = 2'b01;
            if (mem_valid_q && mem_we_q && (mem_rd_q != 5'd0) && (mem_rd_q == ex_rs2_q))
                fwd_b = 2'b10;
            else if (wb_valid_q && wb_we_q && (wb_rd_q != 5'd0) && (wb_rd_q == ex_rs2_q))
                fwd_b = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_RUN;
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
            ex_rd_q     <= 5'd0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= 5'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            wb_valid_q  <= mem_valid_q;
            wb_we_q     <= mem_we_q;
            wb_rd_q     <= mem_rd_q;
            mem_valid_q <= ex_valid_q;
            mem_we_q    <= ex_we_q;
            mem_rd_q    <= ex_rd_q;
            if (flush_ex_d) begin
                ex_valid_q <= 1'b0;
                ex_we_q    <= 1'b0;
                ex_mr_q    <= 1'b0;
                ex_rs1_q   <= 5'd0;
                ex_rs2_q   <= 5'd0;
                ex_rd_q    <= 5'd0;
            end else begin
                ex_valid_q <= valid_id;
                ex_we_q    <= reg_write_id;
                ex_mr_q    <= mem_read_id;
                ex_rs1_q   <= rs1_id;
                ex_rs2_q   <= rs2_id;
                ex_rd_q    <= rd_id;
            end
            if (stall_d && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_id_d && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

endmodule
